servo_pwm_capture: RTL
======================

Name: servo_pwm_capture

Overview:
- Receive-side counterpart of the team's servo PWM generator.
- Measures high time and period of an incoming 50 Hz servo PWM waveform on a 100 MHz sclk and publishes both as cycle counts with a one-cycle valid strobe.
- Flags out-of-range pulse widths and loss of signal.
- Used to loop back and check the generator, or to decode an external servo command.

Parameters:
- CNT_W, 32, width of all counters and measurement outputs.
- PULSE_MIN, 50_000, minimum legal high time in sclk cycles (0.5 ms).
- PULSE_MAX, 250_000, maximum legal high time in sclk cycles (2.5 ms).
- TIMEOUT_CYC, 4_000_000, cycles without a rising edge before signal is declared lost (40 ms).

Ports:
- sclk  input  1  system clock, 100 MHz; all logic on posedge.
- s_rst_n  input  1  synchronous active-low reset.
- pwm_in  input  1  asynchronous PWM input.
- width_out  output  CNT_W  last measured high time, in sclk cycles.
- period_out  output  CNT_W  last measured rising-to-rising period, in sclk cycles.
- meas_valid  output  1  one-cycle strobe: width_out/period_out updated this cycle.
- range_err  output  1  valid with meas_valid: width_out < PULSE_MIN or > PULSE_MAX.
- signal_lost  output  1  level: no rising edge for TIMEOUT_CYC cycles.

Behaviour:
- Reset (s_rst_n=0 at posedge): sync flops s0,s1,s2=0; counters=0; width_out=0, period_out=0, meas_valid=0, range_err=0, signal_lost=0; state IDLE. Reset mid-measurement discards the partial measurement.
- Input path: pwm_in -> s0 -> s1 -> s2. rise = s1 & ~s2; fall = ~s1 & s2.
- hi_cnt:
  - set to 1 on rise;
  - increments while s1=1 and no rise;
  - latched into hi_lat on fall.
- per_cnt:
  - set to 1 on rise;
  - increments otherwise;
  - saturates at TIMEOUT_CYC.
- For an ideal input with N cycles high and P cycles per period: hi_lat=N, published period=P.
- State machine:
  - IDLE: wait for rise -> HIGH. No publish; the first period is always discarded.
  - HIGH: on fall -> LOW (latch hi_lat). If per_cnt reaches TIMEOUT_CYC (stuck high) -> IDLE.
  - LOW:
    - On rise -> HIGH and publish: width_out<=hi_lat, period_out<=per_cnt, meas_valid<=1, range_err<=(hi_lat<PULSE_MIN)|(hi_lat>PULSE_MAX), signal_lost<=0.
    - If per_cnt reaches TIMEOUT_CYC -> IDLE.
- Latency: meas_valid is high in the cycle after the 3rd sclk edge that samples pwm_in high. It is registered, exactly 1 cycle wide.
- Timeout: entering IDLE from HIGH or LOW via timeout sets signal_lost=1.
  - width_out/period_out hold their last values.
  - range_err cleared to 0.
  - signal_lost stays 1 until the next publish.
  - No meas_valid on timeout.
- Simultaneous rise and timeout in the same cycle: rise wins; publish occurs, no loss flag.
- range_err and width_out/period_out hold between strobes; meas_valid is 0 except on publish cycles.
- Glitches: a 1-cycle high pulse is a legal measurement (width 1, range_err=1). No filtering beyond the synchronizer.
- All comparisons unsigned, CNT_W wide. Counters never wrap (saturation at TIMEOUT_CYC; TIMEOUT_CYC < 2^CNT_W is required).

Test Plan (sim params: PULSE_MIN=50, PULSE_MAX=250, TIMEOUT_CYC=400):
- 3 periods of 200 cycles, 150 high -> no strobe for the first period; then meas_valid pulses with width_out=150, period_out=200, range_err=0, signal_lost=0.
- Width sweep 49/50/250/251 high in 300-cycle periods -> range_err=1,0,0,1 respectively, widths reported exactly.
- Stop toggling (hold low) after a valid period -> signal_lost=1 exactly 400 cycles after the last rise is detected; width_out/period_out unchanged; no meas_valid. Resume 200/100 -> first period discarded, then strobe with signal_lost cleared.
- Hold pwm_in high for 500 cycles -> signal_lost=1 at per_cnt=400; on release and resume, recovery is as above.
- Assert s_rst_n=0 mid-HIGH, then release -> all outputs 0; the next complete period after the first rise publishes correctly.
- pwm_in rise exactly when per_cnt reaches 400 -> meas_valid=1 with period_out=400, signal_lost=0.

Source files
------------

// File: rtl/servo_pwm_capture.sv
// servo_pwm_capture: measures the high time and rising-to-rising period of a
// servo PWM input. Each complete period is published as cycle counts with a
// one-cycle strobe. The block also flags out-of-range pulses and loss of signal.
module servo_pwm_capture #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned PULSE_MIN   = 50_000,
    parameter int unsigned PULSE_MAX   = 250_000,
    parameter int unsigned TIMEOUT_CYC = 4_000_000
) (
    input  logic             sclk,
    input  logic             s_rst_n,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] width_out,
    output logic [CNT_W-1:0] period_out,
    output logic             meas_valid,
    output logic             range_err,
    output logic             signal_lost
);

    localparam logic [CNT_W-1:0] L_PULSE_MIN = CNT_W'(PULSE_MIN);
    localparam logic [CNT_W-1:0] L_PULSE_MAX = CNT_W'(PULSE_MAX);
    localparam logic [CNT_W-1:0] L_TIMEOUT   = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] L_ONE       = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_LOW
    } state_t;

    logic             r_s0, r_s1, r_s2;
    logic [CNT_W-1:0] r_hi_cnt;
    logic [CNT_W-1:0] r_per_cnt;
    logic [CNT_W-1:0] r_hi_lat;
    logic [CNT_W-1:0] r_width;
    logic [CNT_W-1:0] r_period;
    logic             r_valid;
    logic             r_err;
    logic             r_lost;
    state_t           r_state;

    logic w_rise;
    logic w_fall;
    logic w_timeout;
    logic w_hi_sat;

    // Edge detection is done between the 2nd and 3rd flop, so s0/s1 absorb metastability.
    assign w_rise    = r_s1 & ~r_s2;
    assign w_fall    = ~r_s1 & r_s2;
    assign w_timeout = (r_per_cnt == L_TIMEOUT);
    assign w_hi_sat  = (r_hi_cnt == L_TIMEOUT);

    // Three-flop synchronizer for the asynchronous PWM input.
    always_ff @(posedge sclk) begin
        if (!s_rst_n) begin
            r_s0 <= 1'b0;
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make this a real shift chain; with
            // blocking ones, pwm_in would fall through all three flops in one edge.
            r_s0 <= pwm_in;
            r_s1 <= r_s0;
            r_s2 <= r_s1;
        end
    end

    // High-time and period counters. Both restart at 1 on a rise and saturate at the timeout.
    always_ff @(posedge sclk) begin
        if (!s_rst_n) begin
            r_hi_cnt  <= '0;
            r_per_cnt <= '0;
            r_hi_lat  <= '0;
        end else begin
            if (w_rise)
                r_hi_cnt <= L_ONE;
            else if (r_s1 && !w_hi_sat)
                r_hi_cnt <= r_hi_cnt + L_ONE;

            if (w_rise)
                r_per_cnt <= L_ONE;
            else if (!w_timeout)
                r_per_cnt <= r_per_cnt + L_ONE;

            if (w_fall)
                r_hi_lat <= r_hi_cnt;
        end
    end

    // Measurement FSM with registered outputs: publish on the rise that closes a period, drop to IDLE on timeout.
    always_ff @(posedge sclk) begin
        if (!s_rst_n) begin
            r_state  <= ST_IDLE;
            r_width  <= '0;
            r_period <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_lost   <= 1'b0;
        end else begin
            // NOTE: the strobe defaults low every cycle and only the publish branch
            // raises it, which guarantees a single-cycle pulse.
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // The period containing the first rise is never complete; it is skipped.
                    if (w_rise)
                        r_state <= ST_HIGH;
                end
                ST_HIGH: begin
                    // If a fall coincides with the timeout, the fall is taken; LOW then times out one cycle later.
                    if (w_fall) begin
                        r_state <= ST_LOW;
                    end else if (w_timeout) begin
                        r_state <= ST_IDLE;
                        r_lost  <= 1'b1;
                        r_err   <= 1'b0;
                    end
                end
                ST_LOW: begin
                    // A rise has priority over a timeout that occurs in the same cycle.
                    if (w_rise) begin
                        r_state  <= ST_HIGH;
                        r_width  <= r_hi_lat;
                        r_period <= r_per_cnt;
                        r_valid  <= 1'b1;
                        r_err    <= (r_hi_lat < L_PULSE_MIN) || (r_hi_lat > L_PULSE_MAX);
                        r_lost   <= 1'b0;
                    end else if (w_timeout) begin
                        r_state <= ST_IDLE;
                        r_lost  <= 1'b1;
                        r_err   <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign width_out   = r_width;
    assign period_out  = r_period;
    assign meas_valid  = r_valid;
    assign range_err   = r_err;
    assign signal_lost = r_lost;

endmodule
